// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared sample/coefficient types and FIR geometry
package fir_pkg;

  localparam int NUM_TAPS = 29;
  localparam int NUM_COEF = 15;
  localparam int SAMP_W   = 24;
  localparam int COEF_W   = 27;

  typedef struct packed {
    logic signed [SAMP_W-1:0] I;
    logic signed [SAMP_W-1:0] Q;
  } Samp;

  typedef struct packed {
    logic signed [COEF_W-1:0] I;
    logic signed [COEF_W-1:0] Q;
  } Coef;

endpackage

// File: rtl/fir_sample_delayline.sv
// rtl/fir_sample_delayline.sv - 29-tap complex sample shift line, tap 0 newest
module fir_sample_delayline
  import fir_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_shift_en,
  input  Samp                   i_samp,
  output Samp [NUM_TAPS-1:0]    o_samp
);

  Samp [NUM_TAPS-1:0] r_line;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_line <= '0;
    end else if (i_shift_en) begin
      r_line <= {r_line[NUM_TAPS-2:0], i_samp};
    end
  end

  assign o_samp = r_line;

endmodule

// File: rtl/fir_controller.sv
// rtl/fir_controller.sv - three-phase FIR frame sequencer, datapath timing tags, coefficient bank
module fir_controller
  import fir_pkg::*;
#(
  parameter int MULT_LAT = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  PushIn,
  input  Samp                   SampIn,
  output logic                  ReadyIn,
  input  logic                  coef_we,
  input  logic [3:0]            coef_addr,
  input  Coef                   coef_data,
  output logic                  CfgBusy,
  output Samp [NUM_TAPS-1:0]    samp,
  output Coef [NUM_COEF-1:0]    coef,
  output logic [1:0]            mux_sel,
  output logic                  partialProductAccumulate_valid,
  output logic                  finalAccumulateRounding_en
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PH0  = 2'd1;
  localparam logic [1:0] ST_PH1  = 2'd2;
  localparam logic [1:0] ST_PH2  = 2'd3;

  localparam int TAG_DEPTH = MULT_LAT + 5;

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic                  w_accept;
  logic                  w_coef_wr;
  logic [TAG_DEPTH-1:0]  r_tag;
  Coef [NUM_COEF-1:0]    r_coef;

  assign ReadyIn  = (r_state == ST_IDLE) || (r_state == ST_PH2);
  assign w_accept = PushIn && ReadyIn;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_nxt = ST_PH0;
      ST_PH0:  w_state_nxt = ST_PH1;
      ST_PH1:  w_state_nxt = ST_PH2;
      ST_PH2:  w_state_nxt = w_accept ? ST_PH0 : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    mux_sel = 2'd0;
    case (r_state)
      ST_PH1:  mux_sel = 2'd1;
      ST_PH2:  mux_sel = 2'd2;
      default: mux_sel = 2'd0;
    endcase
  end

  // r_tag[k] is high k cycles after a frame's PH0 cycle; frames start >= 3 apart so bits never collide
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tag <= '0;
    end else begin
      r_tag <= {r_tag[TAG_DEPTH-2:0], w_accept};
    end
  end

  assign partialProductAccumulate_valid = r_tag[MULT_LAT+2] | r_tag[MULT_LAT+3];
  assign finalAccumulateRounding_en     = r_tag[MULT_LAT+4];
  assign CfgBusy                        = (r_state != ST_IDLE) || (|r_tag);

  assign w_coef_wr = coef_we && !CfgBusy && (coef_addr <= 4'(NUM_COEF-1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_coef <= '0;
    end else begin
      for (int k = 0; k < NUM_COEF; k++) begin
        if (w_coef_wr && (coef_addr == 4'(k))) begin
          r_coef[k] <= coef_data;
        end
      end
    end
  end

  assign coef = r_coef;

  fir_sample_delayline u_delayline (
    .i_clk      (clk),
    .i_rst_n    (reset),
    .i_shift_en (w_accept),
    .i_samp     (SampIn),
    .o_samp     (samp)
  );

endmodule

// File: tb/tb_fir_controller.sv
// tb/tb_fir_controller.sv - self-checking bench for fir_controller against a frame-timing reference model
module tb_fir_controller;
  import fir_pkg::*;

  localparam int L = 2;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                PushIn = 1'b0;
  Samp                 SampIn = '0;
  logic                ReadyIn;
  logic                coef_we = 1'b0;
  logic [3:0]          coef_addr = 4'd0;
  Coef                 coef_data = '0;
  logic                CfgBusy;
  Samp [NUM_TAPS-1:0]  samp;
  Coef [NUM_COEF-1:0]  coef;
  logic [1:0]          mux_sel;
  logic                acc_valid;
  logic                final_en;

  fir_controller #(.MULT_LAT(L)) dut (
    .clk                            (clk),
    .reset                          (reset),
    .PushIn                         (PushIn),
    .SampIn                         (SampIn),
    .ReadyIn                        (ReadyIn),
    .coef_we                        (coef_we),
    .coef_addr                      (coef_addr),
    .coef_data                      (coef_data),
    .CfgBusy                        (CfgBusy),
    .samp                           (samp),
    .coef                           (coef),
    .mux_sel                        (mux_sel),
    .partialProductAccumulate_valid (acc_valid),
    .finalAccumulateRounding_en     (final_en)
  );

  always #5 clk = ~clk;

  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;
  int  starts[$];
  Samp m_samp[NUM_TAPS];
  Coef m_coef[NUM_COEF];
  bit  last_accept = 1'b0;
  int  n_final = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  // phase of the frame occupying the current cycle, -1 when idle
  function automatic int cur_phase();
    foreach (starts[i]) if (cyc >= starts[i] && cyc <= starts[i] + 2) return cyc - starts[i];
    return -1;
  endfunction

  function automatic bit in_flight();
    foreach (starts[i]) if (cyc >= starts[i] && cyc <= starts[i] + L + 4) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit exp_acc();
    foreach (starts[i]) if (cyc == starts[i] + L + 2 || cyc == starts[i] + L + 3) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit exp_fin();
    foreach (starts[i]) if (cyc == starts[i] + L + 4) return 1'b1;
    return 1'b0;
  endfunction

  task automatic step();
    int ph;
    bit e_rdy, e_busy, acc_now, wr_now;
    @(negedge clk);
    if (!reset) begin
      starts.delete();
      foreach (m_samp[i]) m_samp[i] = '0;
      foreach (m_coef[i]) m_coef[i] = '0;
    end
    ph     = cur_phase();
    e_rdy  = (ph < 0) || (ph == 2);
    e_busy = in_flight();
    chk("ReadyIn", ReadyIn, e_rdy);
    chk("mux_sel", mux_sel, (ph < 0) ? 0 : ph);
    chk("acc_valid", acc_valid, exp_acc());
    chk("final_en", final_en, exp_fin());
    chk("CfgBusy", CfgBusy, e_busy);
    for (int i = 0; i < NUM_TAPS; i++) chk($sformatf("samp[%0d]", i), samp[i], m_samp[i]);
    for (int i = 0; i < NUM_COEF; i++) chk($sformatf("coef[%0d]", i), coef[i], m_coef[i]);
    if (final_en) n_final++;
    acc_now = reset && PushIn && e_rdy;
    wr_now  = reset && coef_we && !e_busy && (coef_addr <= 4'd14);
    @(posedge clk);
    if (acc_now) begin
      for (int i = NUM_TAPS - 1; i > 0; i--) m_samp[i] = m_samp[i-1];
      m_samp[0] = SampIn;
      starts.push_back(cyc + 1);
    end
    if (wr_now) m_coef[coef_addr] = coef_data;
    #1;
    cyc++;
    last_accept = acc_now;
  endtask

  function automatic Samp rnd_samp();
    Samp s;
    s.I = 24'($urandom());
    s.Q = 24'($urandom());
    return s;
  endfunction

  function automatic Coef rnd_coef();
    Coef c;
    c.I = 27'($urandom());
    c.Q = 27'($urandom());
    return c;
  endfunction

  initial begin
    Samp first;
    int  nacc;

    reset = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    step();

    // single frame with a known sample
    SampIn = '{I: 24'h000100, Q: 24'h0};
    PushIn = 1'b1;
    step();
    PushIn = 1'b0;
    repeat (3) step();
    chk("samp0_I", samp[0].I, 24'h000100);
    repeat (6) step();

    // coefficient write in IDLE, then at address 15, then during PH1
    coef_we = 1'b1; coef_addr = 4'd3; coef_data = '{I: 27'h0400000, Q: 27'h0};
    step();
    coef_we = 1'b0;
    step();
    chk("coef3_I_idle", coef[3].I, 27'h0400000);
    coef_we = 1'b1; coef_addr = 4'd15; coef_data = rnd_coef();
    step();
    coef_we = 1'b0;
    PushIn = 1'b1; SampIn = rnd_samp();
    step();
    PushIn = 1'b0;
    step();
    coef_we = 1'b1; coef_addr = 4'd3; coef_data = rnd_coef();
    step();
    coef_we = 1'b0;
    repeat (8) step();
    chk("coef3_I_busy", coef[3].I, 27'h0400000);

    // write and accept in the same IDLE cycle
    coef_we = 1'b1; coef_addr = 4'd5; coef_data = rnd_coef();
    PushIn = 1'b1; SampIn = rnd_samp();
    step();
    coef_we = 1'b0; PushIn = 1'b0;
    repeat (8) step();

    // ten back-to-back frames
    n_final = 0; nacc = 0;
    PushIn = 1'b1; SampIn = rnd_samp(); first = SampIn;
    for (int k = 0; k < 100 && nacc < 10; k++) begin
      step();
      if (last_accept) begin
        nacc++;
        if (nacc < 10) SampIn = rnd_samp();
        else PushIn = 1'b0;
      end
    end
    PushIn = 1'b0;
    repeat (10) step();
    chk("frames_accepted", nacc, 10);
    chk("final_pulses", n_final, 10);
    chk("samp9_first", samp[9], first);

    // reset during PH1 aborts the frame
    PushIn = 1'b1; SampIn = rnd_samp();
    step();
    PushIn = 1'b0;
    step();
    reset = 1'b0;
    n_final = 0;
    step();
    reset = 1'b1;
    repeat (10) step();
    chk("no_final_after_reset", n_final, 0);
    PushIn = 1'b1; SampIn = rnd_samp();
    step();
    PushIn = 1'b0;
    repeat (8) step();

    // pushes during PH0/PH1 are ignored
    PushIn = 1'b1; SampIn = rnd_samp();
    step();
    SampIn = rnd_samp();
    step();
    step();
    PushIn = 1'b0;
    repeat (8) step();

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      PushIn    = 1'($urandom_range(0, 1));
      coef_we   = ($urandom_range(0, 3) == 0);
      coef_addr = 4'($urandom_range(0, 15));
      coef_data = rnd_coef();
      reset     = ($urandom_range(0, 99) != 0);
      if (last_accept) SampIn = rnd_samp();
      step();
    end
    reset = 1'b1; PushIn = 1'b0; coef_we = 1'b0;
    repeat (10) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fir_controller.md
FIR_CONTROLLER -- requirements
Module: fir_controller

Interface
REQ-001 Parameter: MULT_LAT, 2, latency in cycles of complexMultiplier from registered sum/coef to p_prod valid.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 PushIn  input  1  new input sample offered.
REQ-005 SampIn  input  Samp  input sample (I,Q, 24 bit each).
REQ-006 ReadyIn  output  1  sample accepted this cycle when PushIn & ReadyIn.
REQ-007 coef_we  input  1  coefficient write strobe.
REQ-008 coef_addr  input  4  coefficient index 0..14.
REQ-009 coef_data  input  Coef  coefficient value (I,Q, 27 bit each).
REQ-010 CfgBusy  output  1  high while any frame is in flight; coefficient writes ignored.
REQ-011 samp  output  Samp[28:0]  sample delay line to datapath, samp[0] newest.
REQ-012 coef  output  Coef[14:0]  coefficient bank to datapath.
REQ-013 mux_sel  output  2  phase index to datapath.
REQ-014 partialProductAccumulate_valid  output  1  accumulate enable to datapath.
REQ-015 finalAccumulateRounding_en  output  1  final 5-input sum enable to datapath.

Function
REQ-016 FSM states IDLE, PH0, PH1, PH2; mux_sel = 0 in IDLE/PH0, 1 in PH1, 2 in PH2.
REQ-017 ReadyIn = 1 in IDLE and PH2, else 0.
REQ-018 On accept: samp[0] <= SampIn, samp[i] <= samp[i-1] for i=1..28, at that clock edge; next state PH0.
REQ-019 PH0 -> PH1 -> PH2 unconditionally; PH2 -> PH0 if accept in PH2, else IDLE.
REQ-020 samp SHALL NOT change except on accept; hence stable through all three phases of a frame.
REQ-021 PushIn while ReadyIn=0 SHALL be ignored (no shift, no state change); source holds until accepted.
REQ-022 Frame entering PH0 in cycle S: partialProductAccumulate_valid = 0 in S+1+MULT_LAT, 1 in S+2+MULT_LAT and S+3+MULT_LAT.
REQ-023 finalAccumulateRounding_en = 1 for exactly cycle S+4+MULT_LAT per frame.
REQ-024 Timing generated by a tag shift register (depth MULT_LAT+5) fed by phase markers; back-to-back frames (period 3 cycles) overlap without conflict.
REQ-025 partialProductAccumulate_valid = 0 in every cycle not covered by REQ-022.
REQ-026 CfgBusy = 1 when state != IDLE or any tag bit set.
REQ-027 coef_we & !CfgBusy & coef_addr<=14: coef[coef_addr] <= coef_data next edge; addr 15 or CfgBusy: write dropped.
REQ-028 Coefficient write and sample accept in the same IDLE cycle: both take effect; new coef used by that frame.

Reset
REQ-029 reset low: state IDLE, samp all zero, coef all zero, tags zero, mux_sel 0, both enables 0, ReadyIn 1, CfgBusy 0.
REQ-030 Reset mid-frame aborts frame; no finalAccumulateRounding_en issued for it after release.
REQ-031 Release synchronous to clk via datapath reset synchronizer; first accept possible first cycle after release.

Structure
REQ-032 Samp, Coef, NUM_TAPS=29, NUM_COEF=15 in shared package fir_pkg.
REQ-033 Delay line in sub-module fir_sample_delayline (shift enable, 29 x Samp); FSM, tags, coef bank in fir_controller.

Verification
REQ-034 Reset, PushIn=1 SampIn.I=24'h000100 in IDLE -> samp[0].I=24'h000100, mux_sel 0,1,2 next three cycles, ReadyIn=1 only in PH2.
REQ-035 Single frame, MULT_LAT=2, PH0 at cycle 10 -> acc_valid 0/1/1 in cycles 13/14/15, final_en only in cycle 16.
REQ-036 PushIn held high 10 frames -> one accept every 3 cycles, 10 final_en pulses 3 cycles apart, samp[9] = first sample.
REQ-037 coef_we addr 3 data 27'h0400000 in IDLE -> coef[3].I updated; same write during PH1 or addr 15 -> no change.
REQ-038 reset asserted in PH1 -> outputs at reset values immediately, no final_en after release, next frame timing per REQ-022.
REQ-039 PushIn pulsed during PH0/PH1 only -> ignored, samp unchanged, state returns IDLE after PH2.
